// File: rtl/pool_row_pair_buffer_pkg.sv
// Shared constants for the layer-1 pool stage interface.
// The cs codes here are the ones the 2x2 max-pool stage decodes.
package pool_row_pair_buffer_pkg;

    // Pool-stage state codes
    localparam logic [3:0] CS_POOL_IDLE = 4'd0;
    localparam logic [3:0] CS_SPOOL_1   = 4'd1;

    // Number of pooled output rows for a frame of the given height
    function automatic int pooled_rows(input int rows);
        return rows / 2;
    endfunction

endpackage

// File: rtl/pool_row_pair_buffer_row_reg.sv
// pool_row_reg: one conv row held pixel by pixel, loaded only when load is high.
module pool_row_reg #(
    parameter int DATA_W  = 16,
    parameter int ROW_PIX = 28
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [ROW_PIX*DATA_W-1:0]   d,
    output logic [ROW_PIX*DATA_W-1:0]   q
);

    genvar gi;
    generate
        for (gi = 0; gi < ROW_PIX; gi++) begin : g_pix
            logic [DATA_W-1:0] pix_reg;

            // Capture this pixel on a load, otherwise hold
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pix_reg <= '0;
                end else if (load) begin
                    pix_reg <= d[gi*DATA_W +: DATA_W];
                end
            end

            assign q[gi*DATA_W +: DATA_W] = pix_reg;
        end
    endgenerate

endmodule

// File: rtl/pool_row_pair_buffer.sv
// pool_row_pair_buffer: collects an even/odd conv row pair and presents it to
// the 2x2 max-pool stage, with max_en and res_valid aligned to the pool pipeline.
module pool_row_pair_buffer
    import pool_row_pair_buffer_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ROW_PIX  = 28,
    parameter int ROWS     = 28,
    parameter int POOL_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          row_valid,
    output logic                          row_ready,
    input  logic [ROW_PIX*DATA_W-1:0]     row_data,
    output logic [2*ROW_PIX*DATA_W-1:0]   fm_out,
    output logic [3:0]                    cs,
    output logic [ROW_PIX/2-1:0]          max_en,
    output logic                          res_valid,
    output logic [$clog2(ROWS/2)-1:0]     res_row,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int PAIRS   = pooled_rows(ROWS);
    localparam int CNT_W   = $clog2(ROWS/2);
    localparam int DRAIN_W = $clog2(POOL_LAT + 2);
    localparam logic [CNT_W-1:0]   LAST_PAIR  = CNT_W'(PAIRS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(POOL_LAT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL_EVEN = 3'd1,
        S_FILL_ODD  = 3'd2,
        S_ISSUE     = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     pair_cnt_reg;
    logic [DRAIN_W-1:0]   drain_cnt_reg;
    logic [3:0]           cs_reg;
    logic [CNT_W-1:0]     res_row_reg;
    logic                 frame_done_reg;
    logic                 issue_dly_reg [0:POOL_LAT];

    logic                 xfer;
    logic                 load_even;
    logic                 load_odd;
    logic [ROW_PIX*DATA_W-1:0] even_q;
    logic [ROW_PIX*DATA_W-1:0] odd_q;

    assign row_ready = (state_reg == S_FILL_EVEN) || (state_reg == S_FILL_ODD);
    assign busy      = (state_reg != S_IDLE);
    assign xfer      = row_valid && row_ready;
    assign load_even = xfer && (state_reg == S_FILL_EVEN);
    assign load_odd  = xfer && (state_reg == S_FILL_ODD);

    pool_row_reg #(
        .DATA_W  (DATA_W),
        .ROW_PIX (ROW_PIX)
    ) u_even_row (
        .clk  (clk),
        .rst  (rst),
        .load (load_even),
        .d    (row_data),
        .q    (even_q)
    );

    pool_row_reg #(
        .DATA_W  (DATA_W),
        .ROW_PIX (ROW_PIX)
    ) u_odd_row (
        .clk  (clk),
        .rst  (rst),
        .load (load_odd),
        .d    (row_data),
        .q    (odd_q)
    );

    // Frame sequencing: fill pair, issue one cycle, drain the pool pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            pair_cnt_reg   <= '0;
            drain_cnt_reg  <= '0;
            cs_reg         <= CS_POOL_IDLE;
            res_row_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            cs_reg         <= CS_POOL_IDLE;
            frame_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        pair_cnt_reg <= '0;
                        state_reg    <= S_FILL_EVEN;
                    end
                end
                S_FILL_EVEN: begin
                    if (xfer) begin
                        state_reg <= S_FILL_ODD;
                    end
                end
                S_FILL_ODD: begin
                    if (xfer) begin
                        state_reg <= S_ISSUE;
                        cs_reg    <= CS_SPOOL_1;
                    end
                end
                S_ISSUE: begin
                    state_reg     <= S_DRAIN;
                    drain_cnt_reg <= '0;
                    res_row_reg   <= pair_cnt_reg;
                end
                S_DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        if (pair_cnt_reg == LAST_PAIR) begin
                            state_reg      <= S_DONE;
                            frame_done_reg <= 1'b1;
                        end else begin
                            pair_cnt_reg <= pair_cnt_reg + 1'b1;
                            state_reg    <= S_FILL_EVEN;
                        end
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Head of the alignment line: marks the cycle after ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_dly_reg[0] <= 1'b0;
        end else begin
            issue_dly_reg[0] <= (state_reg == S_ISSUE);
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= POOL_LAT; gi++) begin : g_dly
            // Track the pool unit's internal latency
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    issue_dly_reg[gi] <= 1'b0;
                end else begin
                    issue_dly_reg[gi] <= issue_dly_reg[gi-1];
                end
            end
        end
    endgenerate

    assign fm_out     = {odd_q, even_q};
    assign cs         = cs_reg;
    assign max_en     = {(ROW_PIX/2){issue_dly_reg[0]}};
    assign res_valid  = issue_dly_reg[POOL_LAT];
    assign res_row    = res_row_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_pool_row_pair_buffer.sv
// Directed testbench for pool_row_pair_buffer.
module tb_pool_row_pair_buffer;
    import pool_row_pair_buffer_pkg::*;

    localparam int DATA_W   = 16;
    localparam int ROW_PIX  = 28;
    localparam int ROWS     = 28;
    localparam int POOL_LAT = 1;
    localparam int PAIRS    = ROWS / 2;
    localparam int PER_PAIR = POOL_LAT + 4;
    localparam int STALL    = 5;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          start = 1'b0;
    logic                          row_valid = 1'b0;
    logic                          row_ready;
    logic [ROW_PIX*DATA_W-1:0]     row_data = '0;
    logic [2*ROW_PIX*DATA_W-1:0]   fm_out;
    logic [3:0]                    cs;
    logic [ROW_PIX/2-1:0]          max_en;
    logic                          res_valid;
    logic [$clog2(ROWS/2)-1:0]     res_row;
    logic                          busy;
    logic                          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int res_cyc_q[$];
    int res_row_q[$];
    int issue_cyc_q[$];
    int issue_e0_q[$];
    int issue_o0_q[$];
    int issue_e27_q[$];
    int maxen_cyc_q[$];
    int maxen_val_q[$];
    int fd_cyc_q[$];

    pool_row_pair_buffer #(
        .DATA_W   (DATA_W),
        .ROW_PIX  (ROW_PIX),
        .ROWS     (ROWS),
        .POOL_LAT (POOL_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .fm_out     (fm_out),
        .cs         (cs),
        .max_en     (max_en),
        .res_valid  (res_valid),
        .res_row    (res_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (res_valid) begin
            res_cyc_q.push_back(cyc);
            res_row_q.push_back(int'(res_row));
            $display("res_valid row %0d at cycle %0d", res_row, cyc);
        end
        if (cs == CS_SPOOL_1) begin
            issue_cyc_q.push_back(cyc);
            issue_e0_q.push_back(int'(fm_out[0 +: DATA_W]));
            issue_o0_q.push_back(int'(fm_out[ROW_PIX*DATA_W +: DATA_W]));
            issue_e27_q.push_back(int'(fm_out[27*DATA_W +: DATA_W]));
        end
        if (max_en != '0) begin
            maxen_cyc_q.push_back(cyc);
            maxen_val_q.push_back(int'(max_en));
        end
        if (frame_done) begin
            fd_cyc_q.push_back(cyc);
            $display("frame_done at cycle %0d", cyc);
        end
    end

    function automatic logic [ROW_PIX*DATA_W-1:0] make_row(input int k);
        logic [ROW_PIX*DATA_W-1:0] r;
        r = '0;
        for (int p = 0; p < ROW_PIX; p++) r[p*DATA_W +: DATA_W] = DATA_W'(k*32 + p);
        return r;
    endfunction

    task automatic clear_logs();
        res_cyc_q.delete(); res_row_q.delete();
        issue_cyc_q.delete(); issue_e0_q.delete(); issue_o0_q.delete(); issue_e27_q.delete();
        maxen_cyc_q.delete(); maxen_val_q.delete(); fd_cyc_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (row_ready !== 1'b0 || cs !== CS_POOL_IDLE || max_en !== '0 || res_valid !== 1'b0 ||
            res_row !== '0 || busy !== 1'b0 || frame_done !== 1'b0 || fm_out !== '0) begin
            n_fail++;
            $display("FAIL %s: rr=%b cs=%h max_en=%h rv=%b row=%0d busy=%b fd=%b fm_nonzero=%b, required all zero/idle",
                     tag, row_ready, cs, max_en, res_valid, res_row, busy, frame_done, (fm_out != '0));
        end
    endtask

    // Streams one frame; stall_pair/restart_row/abort_pair < 0 disable the scenario
    task automatic run_frame(input string name, input int stall_pair, input int restart_row,
                             input int abort_pair);
        int  s, k, stall_left, off;
        bit  done, restarted;
        clear_logs();
        k = 0; stall_left = 0; done = 0; restarted = 0;
        @(negedge clk);
        start = 1'b1; row_valid = 1'b0; s = cyc;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_pair >= 0 && issue_cyc_q.size() == abort_pair + 1 && max_en != '0) begin
                rst = 1'b1; row_valid = 1'b0;
                #1;
                check_reset_values({name, "_abort_immediate"});
                @(negedge clk); @(negedge clk);
                rst = 1'b0;
                repeat (20) @(negedge clk);
                n_checks++;
                if (fd_cyc_q.size() !== 0) begin
                    n_fail++;
                    $display("FAIL %s_no_frame_done: got %0d pulses, required 0", name, fd_cyc_q.size());
                end
                n_checks++;
                if (res_cyc_q.size() !== abort_pair) begin
                    n_fail++;
                    $display("FAIL %s_res_count: got %0d, required %0d", name, res_cyc_q.size(), abort_pair);
                end
                check_reset_values({name, "_after_abort"});
                return;
            end
            if (restart_row >= 0 && !restarted && k == restart_row) begin
                start = 1'b1; restarted = 1;
            end
            if (k < ROWS && stall_left == 0) begin
                row_valid = 1'b1; row_data = make_row(k);
            end else begin
                row_valid = 1'b0;
            end
            if (stall_left > 0) begin
                n_checks++;
                if (row_ready !== 1'b1 || cs === CS_SPOOL_1) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold: row_ready=%b cs=%h, required 1 and not SPOOL_1", name, row_ready, cs);
                end
                stall_left--;
            end
            if (row_valid && row_ready) begin
                k++;
                if (k == 2*stall_pair + 1) stall_left = STALL;
            end
            if (fd_cyc_q.size() > 0) begin
                done = 1;
                break;
            end
        end
        row_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: frame_done not seen, required within 600 cycles", name);
        end
        n_checks++;
        if (res_cyc_q.size() !== PAIRS) begin
            n_fail++;
            $display("FAIL %s_res_count: got %0d, required %0d", name, res_cyc_q.size(), PAIRS);
        end
        for (int i = 0; i < PAIRS && i < res_cyc_q.size(); i++) begin
            off = (stall_pair >= 0 && i >= stall_pair) ? STALL : 0;
            n_checks++;
            if (res_row_q[i] !== i || res_cyc_q[i] !== s + PER_PAIR + PER_PAIR*i + off) begin
                n_fail++;
                $display("FAIL %s_res[%0d]: row=%0d cyc=%0d, required row=%0d cyc=%0d",
                         name, i, res_row_q[i], res_cyc_q[i], i, s + PER_PAIR + PER_PAIR*i + off);
            end
        end
        n_checks++;
        if (issue_cyc_q.size() !== PAIRS || maxen_cyc_q.size() !== PAIRS) begin
            n_fail++;
            $display("FAIL %s_issue_count: issues=%0d max_en=%0d, required %0d each",
                     name, issue_cyc_q.size(), maxen_cyc_q.size(), PAIRS);
        end
        for (int i = 0; i < PAIRS && i < issue_cyc_q.size() && i < maxen_cyc_q.size(); i++) begin
            off = (stall_pair >= 0 && i >= stall_pair) ? STALL : 0;
            n_checks++;
            if (issue_cyc_q[i] !== s + 3 + PER_PAIR*i + off || issue_e0_q[i] !== 64*i ||
                issue_o0_q[i] !== 64*i + 32 || issue_e27_q[i] !== 64*i + 27) begin
                n_fail++;
                $display("FAIL %s_issue[%0d]: cyc=%0d e0=%0d o0=%0d e27=%0d, required cyc=%0d e0=%0d o0=%0d e27=%0d",
                         name, i, issue_cyc_q[i], issue_e0_q[i], issue_o0_q[i], issue_e27_q[i],
                         s + 3 + PER_PAIR*i + off, 64*i, 64*i + 32, 64*i + 27);
            end
            n_checks++;
            if (maxen_cyc_q[i] !== issue_cyc_q[i] + 1 || maxen_val_q[i] !== 32'h3FFF) begin
                n_fail++;
                $display("FAIL %s_max_en[%0d]: cyc=%0d val=%h, required cyc=%0d val=3fff",
                         name, i, maxen_cyc_q[i], maxen_val_q[i], issue_cyc_q[i] + 1);
            end
        end
        n_checks++;
        if (fd_cyc_q.size() !== 1 || (res_cyc_q.size() > 0 && fd_cyc_q.size() > 0 &&
            fd_cyc_q[0] !== res_cyc_q[res_cyc_q.size()-1] + 1)) begin
            n_fail++;
            $display("FAIL %s_frame_done: pulses=%0d cyc=%0d, required 1 pulse at last res_valid+1",
                     name, fd_cyc_q.size(), (fd_cyc_q.size() > 0) ? fd_cyc_q[0] : -1);
        end
        n_checks++;
        if (busy !== 1'b0 || row_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_after: busy=%b row_ready=%b, required 0 0", name, busy, row_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset_release");
    endtask

    task automatic test_idle_no_start();
        row_valid = 1'b1;
        row_data  = make_row(99);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (row_ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_start: row_ready=%b busy=%b, required 0 0", row_ready, busy);
            end
        end
        row_valid = 1'b0;
    endtask

    task automatic test_full_frame();
        run_frame("full_frame", -1, -1, -1);
    endtask

    task automatic test_stall();
        run_frame("stall", 2, -1, -1);
    endtask

    task automatic test_start_while_busy();
        run_frame("start_busy", -1, 10, -1);
    endtask

    task automatic test_abort();
        run_frame("abort", -1, -1, 5);
        run_frame("after_abort", -1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_idle_no_start();
        test_full_frame();
        test_stall();
        test_start_while_busy();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
